// File: rtl/flow_tick_ctrl_pkg.sv
// Shared types for the flow tick controller.
//  - flow_state_t : run/direction/pause mode
//  - speed_t      : 2-bit speed level (0 = fastest)
//  - next_mode()  : mode sequence RUN_RIGHT -> RUN_LEFT -> PAUSE -> RUN_RIGHT
package flow_pkg;

    typedef enum logic [1:0] {
        RUN_RIGHT = 2'd0,
        RUN_LEFT  = 2'd1,
        PAUSE     = 2'd2
    } flow_state_t;

    typedef logic [1:0] speed_t;

    localparam speed_t SPEED_MAX = 2'd3;

    // Mode sequence; the unused encoding recovers to RUN_RIGHT.
    function automatic flow_state_t next_mode(input flow_state_t cur);
        flow_state_t nxt;
        case (cur)
            RUN_RIGHT: nxt = RUN_LEFT;
            RUN_LEFT:  nxt = PAUSE;
            PAUSE:     nxt = RUN_RIGHT;
            default:   nxt = RUN_RIGHT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/flow_tick_ctrl_if.sv
// Button inputs and LED-stage control outputs of the flow tick controller.
//  btn_speed_n / btn_mode_n : raw active-low buttons
//  step_tick                : 1-cycle advance pulse
//  dir_left / paused        : mode status
//  speed_level              : current speed level
//  slave  modport : the controller
//  master modport : the button/LED side
interface flow_tick_ctrl_if;
    import flow_pkg::*;

    logic   btn_speed_n;
    logic   btn_mode_n;
    logic   step_tick;
    logic   dir_left;
    logic   paused;
    speed_t speed_level;

    modport slave (
        input  btn_speed_n,
        input  btn_mode_n,
        output step_tick,
        output dir_left,
        output paused,
        output speed_level
    );

    modport master (
        output btn_speed_n,
        output btn_mode_n,
        input  step_tick,
        input  dir_left,
        input  paused,
        input  speed_level
    );

endinterface

// File: rtl/flow_tick_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, debounce counter, press pulse.
//  clk_in : clock
//  rst_n  : async active-low reset
//  btn_n  : raw active-low button, asynchronous to clk_in
//  press  : registered 1-cycle pulse on each accepted press (debounced 1->0)
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 2400
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
        $error("btn_debounce: DEBOUNCE_CYCLES must be at least 2");
    end

    logic            sync1_r;
    logic            sync2_r;
    logic            deb_r;
    logic            press_r;
    logic [DB_W-1:0] cnt_r;
    logic            differ_s;
    logic            toggle_s;

    // Accept a change only after the synced value has differed for DEBOUNCE_CYCLES edges.
    always_comb begin
        differ_s = (sync2_r != deb_r);
        toggle_s = differ_s && (cnt_r == DB_LAST);
    end

    // Synchroniser, debounce counter, debounced level and press pulse.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            deb_r   <= 1'b1;
            cnt_r   <= DB_ZERO;
            press_r <= 1'b0;
        end else begin
            sync1_r <= btn_n;
            sync2_r <= sync1_r;
            if (toggle_s) begin
                deb_r <= ~deb_r;
                cnt_r <= DB_ZERO;
            end else if (differ_s) begin
                deb_r <= deb_r;
                cnt_r <= cnt_r + DB_ONE;
            end else begin
                deb_r <= deb_r;
                cnt_r <= DB_ZERO;
            end
            // Only the released->pressed edge is an event.
            press_r <= toggle_s & deb_r;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/flow_tick_ctrl.sv
// Upstream control stage for the rotating-LED flow block.
// Debounces the speed and mode buttons, holds the run/direction/pause mode
// and the speed level, and emits step_tick every BASE_TICKS << speed_level cycles.
//  clk_in : PLL clock, all logic on posedge
//  rst_n  : async active-low reset
//  bus    : slave side of flow_tick_ctrl_if (buttons in, tick/status out)
module flow_tick_ctrl
    import flow_pkg::*;
#(
    parameter int BASE_TICKS      = 2400,
    parameter int DEBOUNCE_CYCLES = 2400
) (
    input  logic             clk_in,
    input  logic             rst_n,
    flow_tick_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(BASE_TICKS * 8);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_ZERO = cnt_t'(0);
    localparam cnt_t CNT_ONE  = cnt_t'(1);

    if (BASE_TICKS < 2) begin : g_chk_base
        $error("flow_tick_ctrl: BASE_TICKS must be at least 2");
    end
    if ((BASE_TICKS * 8 - 1) >= (1 << CNT_W)) begin : g_chk_width
        $error("flow_tick_ctrl: slowest period does not fit the tick counter");
    end

    // Reload value for the period of a given speed level.
    function automatic cnt_t period_last(input speed_t lvl);
        return cnt_t'((BASE_TICKS << lvl) - 1);
    endfunction

    logic        speed_press_s;
    logic        mode_press_s;
    flow_state_t state_r;
    flow_state_t state_next_s;
    speed_t      speed_r;
    speed_t      speed_next_s;
    cnt_t        cnt_r;
    cnt_t        cnt_next_s;
    logic        tick_r;
    logic        tick_next_s;
    logic        dir_left_r;
    logic        dir_left_next_s;
    logic        paused_r;
    logic        run_s;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .btn_n  (bus.btn_speed_n),
        .press  (speed_press_s)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .btn_n  (bus.btn_mode_n),
        .press  (mode_press_s)
    );

    // Next mode, speed, direction and tick counter.
    always_comb begin
        state_next_s    = mode_press_s ? next_mode(state_r) : state_r;
        speed_next_s    = speed_press_s ? ((speed_r == SPEED_MAX) ? 2'd0 : speed_r + 2'd1) : speed_r;
        // The counter only advances while running on both sides of the edge,
        // so the edge entering PAUSE neither ticks nor consumes a count.
        run_s           = (state_r != PAUSE) && (state_next_s != PAUSE);
        cnt_next_s      = cnt_r;
        tick_next_s     = 1'b0;
        dir_left_next_s = dir_left_r;

        // A speed change restarts the period and wins over a due tick.
        if (speed_press_s) begin
            cnt_next_s  = period_last(speed_next_s);
            tick_next_s = 1'b0;
        end else if (run_s) begin
            if (cnt_r == CNT_ZERO) begin
                cnt_next_s  = period_last(speed_r);
                tick_next_s = 1'b1;
            end else begin
                cnt_next_s  = cnt_r - CNT_ONE;
                tick_next_s = 1'b0;
            end
        end else begin
            cnt_next_s  = cnt_r;
            tick_next_s = 1'b0;
        end

        // PAUSE keeps whichever direction was last running.
        case (state_next_s)
            RUN_RIGHT: dir_left_next_s = 1'b0;
            RUN_LEFT:  dir_left_next_s = 1'b1;
            default:   dir_left_next_s = dir_left_r;
        endcase
    end

    // State, speed, counter and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RUN_RIGHT;
            speed_r    <= 2'd0;
            cnt_r      <= cnt_t'(BASE_TICKS - 1);
            tick_r     <= 1'b0;
            dir_left_r <= 1'b0;
            paused_r   <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            speed_r    <= speed_next_s;
            cnt_r      <= cnt_next_s;
            tick_r     <= tick_next_s;
            dir_left_r <= dir_left_next_s;
            paused_r   <= (state_next_s == PAUSE);
        end
    end

    assign bus.step_tick   = tick_r;
    assign bus.dir_left    = dir_left_r;
    assign bus.paused      = paused_r;
    assign bus.speed_level = speed_r;

endmodule

// File: tb/tb_flow_tick_ctrl.sv
// Testbench for flow_tick_ctrl with BASE_TICKS=5, DEBOUNCE_CYCLES=4.
// A behavioural model is advanced once per clock edge and all outputs are compared each cycle.
module tb_flow_tick_ctrl;
    localparam int BT = 5;
    localparam int DC = 4;

    logic clk_in;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    flow_tick_ctrl_if bus();

    flow_tick_ctrl #(.BASE_TICKS(BT), .DEBOUNCE_CYCLES(DC)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Model state. Mode: 0 = run right, 1 = run left, 2 = pause.
    int          m_mode, m_speed, m_cnt;
    bit          m_tick, m_dirl;
    bit          m_deb_s, m_deb_m, m_pend_s, m_pend_m;
    bit [DC+1:0] m_hist_s, m_hist_m;   // bit i = raw level sampled i edges ago

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_speed = 0; m_cnt = BT - 1; m_tick = 0; m_dirl = 0;
        m_deb_s = 1; m_deb_m = 1; m_pend_s = 0; m_pend_m = 0;
        m_hist_s = '1; m_hist_m = '1;
    endtask

    // A level is accepted once the synchronised value (2 edges old) has
    // differed from the debounced level for DC consecutive edges.
    task automatic model_button(input logic raw, inout bit [DC+1:0] h, inout bit deb, output bit press);
        bit [DC-1:0] win;
        h = {h[DC:0], raw};
        win = h[DC+1:2];
        press = 0;
        if ((deb && win == '0) || (!deb && win == '1)) begin
            press = deb;
            deb = !deb;
        end
    endtask

    task automatic model_edge();
        int nm, ns;
        bit ps, pm;
        nm = m_pend_m ? (m_mode + 1) % 3 : m_mode;
        ns = m_pend_s ? (m_speed + 1) % 4 : m_speed;
        if (m_pend_s) begin
            m_cnt = (BT << ns) - 1; m_tick = 0;
        end else if (m_mode != 2 && nm != 2) begin
            if (m_cnt == 0) begin m_cnt = (BT << m_speed) - 1; m_tick = 1; end
            else begin m_cnt--; m_tick = 0; end
        end else m_tick = 0;
        if (nm == 1) m_dirl = 1;
        else if (nm == 0) m_dirl = 0;
        m_mode = nm; m_speed = ns;
        model_button(bus.btn_speed_n, m_hist_s, m_deb_s, ps);
        model_button(bus.btn_mode_n, m_hist_m, m_deb_m, pm);
        m_pend_s = ps; m_pend_m = pm;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".step_tick"}, 32'(bus.step_tick), 32'(m_tick));
        check({tag, ".dir_left"}, 32'(bus.dir_left), 32'(m_dirl));
        check({tag, ".paused"}, 32'(bus.paused), 32'(m_mode == 2));
        check({tag, ".speed_level"}, 32'(bus.speed_level), 32'(m_speed));
    endtask

    task automatic step();
        @(posedge clk_in); #1;
        cyc++;
        model_edge();
        compare_all("run");
    endtask

    task automatic rst_cycle();
        @(posedge clk_in); #1;
        check("rst.step_tick", 32'(bus.step_tick), 32'd0);
        check("rst.dir_left", 32'(bus.dir_left), 32'd0);
        check("rst.paused", 32'(bus.paused), 32'd0);
        check("rst.speed_level", 32'(bus.speed_level), 32'd0);
    endtask

    task automatic press_btn(input bit is_speed, input int hold, input int gap);
        if (is_speed) bus.btn_speed_n = 1'b0; else bus.btn_mode_n = 1'b0;
        repeat (hold) step();
        if (is_speed) bus.btn_speed_n = 1'b1; else bus.btn_mode_n = 1'b1;
        repeat (gap) step();
    endtask

    int first, fall, chg, ticks, target, n;
    bit found;

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst_n = 1'b0; bus.btn_speed_n = 1'b1; bus.btn_mode_n = 1'b1;
        model_reset();
        repeat (3) rst_cycle();
        @(negedge clk_in); rst_n = 1'b1;

        // 1: free run at level 0
        first = -1;
        for (int i = 0; i < 22; i++) begin
            step();
            if (first < 0 && bus.step_tick) first = cyc;
        end
        check("first_tick_cycle", 32'(first), 32'd5);

        // 2: one clean speed press, then three more to wrap
        bus.btn_speed_n = 1'b0; fall = cyc; chg = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (chg < 0 && bus.speed_level == 2'd1) chg = cyc - fall;
        end
        bus.btn_speed_n = 1'b1;
        repeat (25) step();
        check("speed_latency", 32'(chg), 32'd7);
        for (int i = 0; i < 3; i++) press_btn(1'b1, $urandom_range(5, 9), $urandom_range(45, 60));
        check("speed_wrapped", 32'(bus.speed_level), 32'd0);

        // 3: bounces, then RUN_LEFT, PAUSE, RUN_RIGHT
        for (int i = 0; i < 6; i++) press_btn(1'b0, $urandom_range(1, 3), $urandom_range(1, 4));
        repeat (8) step();
        check("bounce_dir", 32'(bus.dir_left), 32'd0);
        check("bounce_paused", 32'(bus.paused), 32'd0);
        press_btn(1'b0, 6, 12);
        check("run_left_dir", 32'(bus.dir_left), 32'd1);
        press_btn(1'b0, 6, 6);
        ticks = 0;
        for (int i = 0; i < 50; i++) begin step(); ticks += int'(bus.step_tick); end
        check("pause_no_ticks", 32'(ticks), 32'd0);
        check("pause_flag", 32'(bus.paused), 32'd1);
        check("pause_keeps_dir", 32'(bus.dir_left), 32'd1);
        press_btn(1'b0, 6, 30);
        check("resume_paused", 32'(bus.paused), 32'd0);
        check("resume_dir", 32'(bus.dir_left), 32'd0);

        // 4: speed event lands when the counter is due
        target = 6 % (BT << m_speed);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (m_cnt == target) found = 1;
        end
        check("align_reached", 32'(found), 32'd1);
        bus.btn_speed_n = 1'b0;
        repeat (7) step();
        check("collide_no_tick", 32'(bus.step_tick), 32'd0);
        check("collide_speed", 32'(bus.speed_level), 32'd1);
        bus.btn_speed_n = 1'b1;
        n = 0; found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(); n++;
            if (bus.step_tick) found = 1;
        end
        check("collide_next_tick", 32'(n), 32'd10);
        repeat (25) step();

        // 5: both buttons together
        bus.btn_speed_n = 1'b0; bus.btn_mode_n = 1'b0;
        repeat (8) step();
        bus.btn_speed_n = 1'b1; bus.btn_mode_n = 1'b1;
        check("both_speed", 32'(bus.speed_level), 32'd2);
        check("both_dir", 32'(bus.dir_left), 32'd1);
        repeat (30) step();

        // 6: reset mid-period and mid-debounce
        bus.btn_speed_n = 1'b0;
        repeat (4) step();
        #3 rst_n = 1'b0;
        #1 model_reset();
        compare_all("async_rst");
        bus.btn_speed_n = 1'b1;
        repeat (2) rst_cycle();
        @(negedge clk_in); rst_n = 1'b1; cyc = 0;
        repeat (20) step();
        check("no_pending_press", 32'(bus.speed_level), 32'd0);

        // Random button activity against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) bus.btn_speed_n = ~bus.btn_speed_n;
            if ($urandom_range(0, 7) == 0) bus.btn_mode_n = ~bus.btn_mode_n;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
